sfp_txdis_ctrl: RTL and testbench

- Per-port SFP transmitter management for the four GTX 1G lanes X0Y12..X0Y15 of quad 3.
- Drives the TX_DISABLE[3:0] pins consumed by the 1G transceiver/IBERT top level, replacing the tie-to-0.
- Sequences laser enable after module insertion and recovers from TX_FAULT by pulsing TX_DISABLE, latching off after repeated faults.
- Debounces RX_LOS and reports per-port link-ready and state to control logic.

---
 rtl/sfp_ctrl_pkg.sv | 34 +++
 rtl/sfp_port_fsm.sv | 130 +++++++++++++
 rtl/sfp_txdis_ctrl.sv | 43 ++++
 tb/tb_sfp_txdis_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/sfp_ctrl_pkg.sv
// rtl/sfp_ctrl_pkg.sv - state codes, width helpers and 125 MHz timing defaults for SFP TX control
package sfp_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_OFF   = 3'd0,
    ST_INIT  = 3'd1,
    ST_UP    = 3'd2,
    ST_PULSE = 3'd3,
    ST_LATCH = 3'd4
  } port_state_e;

  localparam int DEF_NUM_PORTS   = 4;
  localparam int DEF_INIT_CYC    = 37500000;
  localparam int DEF_PULSE_CYC   = 1250;
  localparam int DEF_LOS_DEB_CYC = 125000;
  localparam int DEF_MAX_RETRY   = 3;

  function automatic int clog2(input int value);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) w = i + 1;
    end
    return w;
  endfunction

  // Counter width that never collapses to zero bits for tiny bench overrides.
  function automatic int cnt_width(input int value);
    int w;
    w = clog2(value);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/sfp_port_fsm.sv
// rtl/sfp_port_fsm.sv - one SFP cage: pin synchronisers, laser enable FSM, retry counter, LOS debounce
module sfp_port_fsm
  import sfp_ctrl_pkg::*;
#(
  parameter int INIT_CYC    = DEF_INIT_CYC,
  parameter int PULSE_CYC   = DEF_PULSE_CYC,
  parameter int LOS_DEB_CYC = DEF_LOS_DEB_CYC,
  parameter int MAX_RETRY   = DEF_MAX_RETRY
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       port_en,
  input  logic       mod_abs,
  input  logic       tx_fault,
  input  logic       rx_los,
  output logic       tx_disable,
  output logic       link_rdy,
  output logic [2:0] port_state,
  output logic       fault_latched
);

  localparam int TMR_W = cnt_width((INIT_CYC > PULSE_CYC) ? INIT_CYC : PULSE_CYC);
  localparam int RET_W = cnt_width(MAX_RETRY + 1);
  localparam int LOS_W = cnt_width(LOS_DEB_CYC);

  localparam logic [TMR_W-1:0] INIT_LAST  = TMR_W'(INIT_CYC - 1);
  localparam logic [TMR_W-1:0] PULSE_LAST = TMR_W'(PULSE_CYC - 1);
  localparam logic [RET_W-1:0] RETRY_MAX  = RET_W'(MAX_RETRY);
  localparam logic [LOS_W-1:0] LOS_LAST   = LOS_W'(LOS_DEB_CYC - 1);

  logic [2:0] sync_q1, sync_q2;
  logic       mod_abs_s, tx_fault_s, rx_los_s;

  port_state_e      state, state_nxt;
  logic [TMR_W-1:0] timer;
  logic [RET_W-1:0] retry_cnt, retry_nxt;
  logic [LOS_W-1:0] los_cnt, los_cnt_nxt;
  logic             los_deb, los_deb_nxt;

  // Synchroniser flops power up in the safe sense: absent, faulted, no signal.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q1 <= 3'b111;
      sync_q2 <= 3'b111;
    end else begin
      sync_q1 <= {mod_abs, tx_fault, rx_los};
      sync_q2 <= sync_q1;
    end
  end

  assign {mod_abs_s, tx_fault_s, rx_los_s} = sync_q2;

  always_comb begin
    state_nxt = state;
    retry_nxt = retry_cnt;
    case (state)
      ST_OFF: begin
        retry_nxt = '0;
        if (port_en && !mod_abs_s) state_nxt = ST_INIT;
      end
      ST_INIT: begin
        if (timer == INIT_LAST) state_nxt = ST_UP;
      end
      ST_UP: begin
        if (tx_fault_s) begin
          if (retry_cnt < RETRY_MAX) begin
            state_nxt = ST_PULSE;
            retry_nxt = retry_cnt + RET_W'(1);
          end else begin
            state_nxt = ST_LATCH;
          end
        end
      end
      ST_PULSE: begin
        if (timer == PULSE_LAST) state_nxt = ST_INIT;
      end
      ST_LATCH: begin
        state_nxt = ST_LATCH;
      end
      default: begin
        state_nxt = ST_OFF;
      end
    endcase
    // Losing the enable or the module beats any fault or timer expiry.
    if (!port_en || mod_abs_s) begin
      state_nxt = ST_OFF;
      retry_nxt = '0;
    end
  end

  always_comb begin
    los_cnt_nxt = '0;
    los_deb_nxt = los_deb;
    if (rx_los_s != los_deb) begin
      if (los_cnt == LOS_LAST) los_deb_nxt = rx_los_s;
      else                     los_cnt_nxt = los_cnt + LOS_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_OFF;
      timer         <= '0;
      retry_cnt     <= '0;
      los_cnt       <= '0;
      los_deb       <= 1'b1;
      tx_disable    <= 1'b1;
      link_rdy      <= 1'b0;
      fault_latched <= 1'b0;
    end else begin
      state     <= state_nxt;
      retry_cnt <= retry_nxt;
      los_cnt   <= los_cnt_nxt;
      los_deb   <= los_deb_nxt;
      if (state_nxt != state)
        timer <= '0;
      else if (state == ST_INIT || state == ST_PULSE)
        timer <= timer + TMR_W'(1);
      else
        timer <= '0;
      // Outputs are decoded from the next state so they line up with the state register.
      tx_disable    <= (state_nxt == ST_OFF) || (state_nxt == ST_PULSE) || (state_nxt == ST_LATCH);
      link_rdy      <= (state_nxt == ST_UP) && !los_deb_nxt;
      fault_latched <= (state_nxt == ST_LATCH);
    end
  end

  assign port_state = state;

endmodule

// File: rtl/sfp_txdis_ctrl.sv
// rtl/sfp_txdis_ctrl.sv - per-port SFP TX_DISABLE sequencing for the quad 3 GTX 1G lanes
module sfp_txdis_ctrl
  import sfp_ctrl_pkg::*;
#(
  parameter int NUM_PORTS   = DEF_NUM_PORTS,
  parameter int INIT_CYC    = DEF_INIT_CYC,
  parameter int PULSE_CYC   = DEF_PULSE_CYC,
  parameter int LOS_DEB_CYC = DEF_LOS_DEB_CYC,
  parameter int MAX_RETRY   = DEF_MAX_RETRY
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_PORTS-1:0]   PORT_EN,
  input  logic [NUM_PORTS-1:0]   MOD_ABS,
  input  logic [NUM_PORTS-1:0]   TX_FAULT,
  input  logic [NUM_PORTS-1:0]   RX_LOS,
  output logic [NUM_PORTS-1:0]   TX_DISABLE,
  output logic [NUM_PORTS-1:0]   LINK_RDY,
  output logic [3*NUM_PORTS-1:0] PORT_STATE,
  output logic [NUM_PORTS-1:0]   FAULT_LATCHED
);

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
    sfp_port_fsm #(
      .INIT_CYC    (INIT_CYC),
      .PULSE_CYC   (PULSE_CYC),
      .LOS_DEB_CYC (LOS_DEB_CYC),
      .MAX_RETRY   (MAX_RETRY)
    ) u_port (
      .clk           (clk),
      .rst           (rst),
      .port_en       (PORT_EN[i]),
      .mod_abs       (MOD_ABS[i]),
      .tx_fault      (TX_FAULT[i]),
      .rx_los        (RX_LOS[i]),
      .tx_disable    (TX_DISABLE[i]),
      .link_rdy      (LINK_RDY[i]),
      .port_state    (PORT_STATE[3*i +: 3]),
      .fault_latched (FAULT_LATCHED[i])
    );
  end

endmodule

// File: tb/tb_sfp_txdis_ctrl.sv
// tb/tb_sfp_txdis_ctrl.sv - directed vector bench for sfp_txdis_ctrl with short timing overrides
module tb_sfp_txdis_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  PORT_EN, MOD_ABS, TX_FAULT, RX_LOS;
  logic [3:0]  TX_DISABLE, LINK_RDY, FAULT_LATCHED;
  logic [11:0] PORT_STATE;

  int checks = 0;
  int errors = 0;

  sfp_txdis_ctrl #(
    .NUM_PORTS   (4),
    .INIT_CYC    (20),
    .PULSE_CYC   (5),
    .LOS_DEB_CYC (8),
    .MAX_RETRY   (2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .PORT_EN       (PORT_EN),
    .MOD_ABS       (MOD_ABS),
    .TX_FAULT      (TX_FAULT),
    .RX_LOS        (RX_LOS),
    .TX_DISABLE    (TX_DISABLE),
    .LINK_RDY      (LINK_RDY),
    .PORT_STATE    (PORT_STATE),
    .FAULT_LATCHED (FAULT_LATCHED)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  en;
    logic [3:0]  abs;
    logic [3:0]  flt;
    logic [3:0]  los;
    int          cyc;
    logic [3:0]  exp_txd;
    logic [3:0]  exp_link;
    logic [11:0] exp_st;
    logic [3:0]  exp_fl;
  } vec_t;

  localparam int NV = 22;
  vec_t vecs [NV];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string nm, input logic [3:0] txd, input logic [3:0] link,
                         input logic [11:0] st, input logic [3:0] fl);
    chk({nm, "_txdis"}, 32'(TX_DISABLE), 32'(txd));
    chk({nm, "_link"},  32'(LINK_RDY),   32'(link));
    chk({nm, "_state"}, 32'(PORT_STATE), 32'(st));
    chk({nm, "_fltlat"}, 32'(FAULT_LATCHED), 32'(fl));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] exp_link;

    // Startup, then three faults on port 1, latch, re-enable, and a fault that pulses again.
    vecs[0]  = '{4'hF, 4'h0, 4'h0, 4'hF, 2,  4'hF, 4'h0, 12'h000, 4'h0};
    vecs[1]  = '{4'hF, 4'h0, 4'h0, 4'hF, 1,  4'h0, 4'h0, 12'h249, 4'h0};
    vecs[2]  = '{4'hF, 4'h0, 4'h0, 4'hF, 19, 4'h0, 4'h0, 12'h249, 4'h0};
    vecs[3]  = '{4'hF, 4'h0, 4'h0, 4'hF, 1,  4'h0, 4'h0, 12'h492, 4'h0};
    vecs[4]  = '{4'hF, 4'h0, 4'h2, 4'hF, 1,  4'h0, 4'h0, 12'h492, 4'h0};
    vecs[5]  = '{4'hF, 4'h0, 4'h0, 4'hF, 2,  4'h2, 4'h0, 12'h49A, 4'h0};
    vecs[6]  = '{4'hF, 4'h0, 4'h0, 4'hF, 5,  4'h0, 4'h0, 12'h48A, 4'h0};
    vecs[7]  = '{4'hF, 4'h0, 4'h0, 4'hF, 20, 4'h0, 4'h0, 12'h492, 4'h0};
    vecs[8]  = '{4'hF, 4'h0, 4'h2, 4'hF, 1,  4'h0, 4'h0, 12'h492, 4'h0};
    vecs[9]  = '{4'hF, 4'h0, 4'h0, 4'hF, 2,  4'h2, 4'h0, 12'h49A, 4'h0};
    vecs[10] = '{4'hF, 4'h0, 4'h0, 4'hF, 5,  4'h0, 4'h0, 12'h48A, 4'h0};
    vecs[11] = '{4'hF, 4'h0, 4'h0, 4'hF, 20, 4'h0, 4'h0, 12'h492, 4'h0};
    vecs[12] = '{4'hF, 4'h0, 4'h2, 4'hF, 1,  4'h0, 4'h0, 12'h492, 4'h0};
    vecs[13] = '{4'hF, 4'h0, 4'h0, 4'hF, 2,  4'h2, 4'h0, 12'h4A2, 4'h2};
    vecs[14] = '{4'hF, 4'h0, 4'h0, 4'hF, 5,  4'h2, 4'h0, 12'h4A2, 4'h2};
    vecs[15] = '{4'hD, 4'h0, 4'h0, 4'hF, 1,  4'h2, 4'h0, 12'h482, 4'h0};
    vecs[16] = '{4'hF, 4'h0, 4'h0, 4'hF, 1,  4'h0, 4'h0, 12'h48A, 4'h0};
    vecs[17] = '{4'hF, 4'h0, 4'h0, 4'hF, 20, 4'h0, 4'h0, 12'h492, 4'h0};
    vecs[18] = '{4'hF, 4'h0, 4'h2, 4'hF, 1,  4'h0, 4'h0, 12'h492, 4'h0};
    vecs[19] = '{4'hF, 4'h0, 4'h0, 4'hF, 2,  4'h2, 4'h0, 12'h49A, 4'h0};
    vecs[20] = '{4'hF, 4'h0, 4'h0, 4'hF, 5,  4'h0, 4'h0, 12'h48A, 4'h0};
    vecs[21] = '{4'hF, 4'h0, 4'h0, 4'hF, 20, 4'h0, 4'h0, 12'h492, 4'h0};

    rst      = 1'b1;
    PORT_EN  = 4'h0;
    MOD_ABS  = 4'hF;
    TX_FAULT = 4'hF;
    RX_LOS   = 4'hF;
    repeat (3) tick();
    chk_all("reset", 4'hF, 4'h0, 12'h000, 4'h0);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      PORT_EN  = vecs[i].en;
      MOD_ABS  = vecs[i].abs;
      TX_FAULT = vecs[i].flt;
      RX_LOS   = vecs[i].los;
      repeat (vecs[i].cyc) tick();
      chk_all($sformatf("row%0d", i), vecs[i].exp_txd, vecs[i].exp_link,
              vecs[i].exp_st, vecs[i].exp_fl);
    end

    // Port 0 single-cycle fault: disable pulse must be exactly five cycles wide.
    TX_FAULT = 4'h1;
    tick();
    TX_FAULT = 4'h0;
    tick();
    chk("p0_pre_pulse", 32'(TX_DISABLE), 32'h0);
    tick();
    chk("p0_pulse_start_txdis", 32'(TX_DISABLE), 32'h1);
    chk("p0_pulse_start_state", 32'(PORT_STATE), 32'h493);
    for (int i = 1; i < 5; i++) begin
      tick();
      chk($sformatf("p0_pulse_c%0d", i), 32'(TX_DISABLE), 32'h1);
    end
    tick();
    chk("p0_pulse_end_txdis", 32'(TX_DISABLE), 32'h0);
    chk("p0_pulse_end_state", 32'(PORT_STATE), 32'h491);
    repeat (20) tick();
    chk("p0_back_up", 32'(PORT_STATE), 32'h492);

    // Port 2 RX_LOS: a 7-cycle glitch is filtered, an 8-cycle drop gets through.
    RX_LOS = 4'hB;
    repeat (7) tick();
    RX_LOS = 4'hF;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk($sformatf("los_glitch_c%0d", i), 32'(LINK_RDY), 32'h0);
    end
    RX_LOS = 4'hB;
    for (int i = 1; i <= 10; i++) begin
      tick();
      exp_link = (i >= 10) ? 4'h4 : 4'h0;
      chk($sformatf("los_hold_c%0d", i), 32'(LINK_RDY), 32'(exp_link));
    end

    // Port 3: module removal and fault together must go to OFF, never PULSE.
    MOD_ABS  = 4'h8;
    TX_FAULT = 4'h8;
    tick();
    chk("p3_abs_c1", 32'(PORT_STATE), 32'h492);
    tick();
    chk("p3_abs_c2", 32'(PORT_STATE), 32'h492);
    tick();
    chk_all("p3_abs_c3", 4'h8, 4'h4, 12'h092, 4'h0);
    repeat (5) tick();
    chk("p3_abs_hold", 32'(PORT_STATE), 32'h092);
    MOD_ABS  = 4'h0;
    TX_FAULT = 4'h0;
    repeat (25) tick();
    chk("p3_back_up", 32'(PORT_STATE), 32'h492);

    // Port 2 leaving UP drops LINK_RDY in the same cycle.
    PORT_EN = 4'hB;
    tick();
    chk_all("p2_disable", 4'h4, 4'h0, 12'h412, 4'h0);
    PORT_EN = 4'hF;
    repeat (21) tick();
    chk_all("p2_reup", 4'h0, 4'h4, 12'h492, 4'h0);

    // Asynchronous reset in the middle of a port 0 pulse.
    TX_FAULT = 4'h1;
    tick();
    TX_FAULT = 4'h0;
    tick();
    tick();
    chk("p0_pulse2_state", 32'(PORT_STATE), 32'h493);
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    chk_all("async_rst", 4'hF, 4'h0, 12'h000, 4'h0);
    tick();
    rst = 1'b0;
    tick();
    chk_all("post_rst_c1", 4'hF, 4'h0, 12'h000, 4'h0);
    tick();
    chk("post_rst_c2", 32'(PORT_STATE), 32'h000);
    tick();
    chk("post_rst_c3_state", 32'(PORT_STATE), 32'h249);
    chk("post_rst_c3_txdis", 32'(TX_DISABLE), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
